// File: rtl/altera_spram_init_if.sv
`default_nettype none
// ============================================================================
// Module   : altera_spram_init_if
// Brief    : User-side port bundle of the initialisable single-port RAM.
// Revision : 1.0 - initial release
// ============================================================================
interface altera_spram_init_if #(
    parameter int RAM_WIDTH  = 32,
    parameter int BYTE_WIDTH = 8,
    parameter int RAM_DEEP   = 10
);
    localparam int c_lanes = RAM_WIDTH / BYTE_WIDTH;

    logic                 init_req;
    logic                 init_busy;
    logic                 init_done;
    logic                 wren;
    logic [c_lanes-1:0]   byte_en;
    logic [RAM_WIDTH-1:0] wdata;
    logic [RAM_DEEP-1:0]  address;
    logic                 ren;
    logic                 rd_vld;
    logic [RAM_WIDTH-1:0] q;

    modport master (
        output init_req, wren, byte_en, wdata, address, ren,
        input  init_busy, init_done, rd_vld, q
    );

    modport slave (
        input  init_req, wren, byte_en, wdata, address, ren,
        output init_busy, init_done, rd_vld, q
    );
endinterface
`default_nettype wire

// File: rtl/altera_spram_init.sv
`default_nettype none
// ============================================================================
// Module   : altera_spram_init
// Brief    : Single-port RAM with byte enables, read-valid pipeline and a
//            fill engine that writes INIT_VALUE to every word.
// Revision : 1.0 - initial release
// ============================================================================
module altera_spram_init #(
    parameter                 DEVICE_ID     = "Stratix V",
    parameter                 BRAM_TYPE     = "AUTO",
    parameter int             RAM_DO_REG    = 0,
    parameter int             RAM_WIDTH     = 32,
    parameter int             BYTE_WIDTH    = 8,
    parameter int             RAM_DEEP      = 10,
    parameter logic [RAM_WIDTH-1:0] INIT_VALUE = '0,
    parameter int             INIT_ON_RESET = 1
) (
    input  wire logic          clock,
    input  wire logic          reset_n,
    altera_spram_init_if.slave bus
);
    localparam int c_lanes = RAM_WIDTH / BYTE_WIDTH;
    localparam int c_depth = 2 ** RAM_DEEP;
    // Counter is one bit wider than the address so the terminal compare never wraps.
    localparam logic [RAM_DEEP:0] c_last = {1'b0, {RAM_DEEP{1'b1}}};
    localparam logic [RAM_DEEP:0] c_one  = {{RAM_DEEP{1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_INIT = 1'b1
    } state_t;

    localparam state_t c_rst_state = (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;

    state_t              r_state;
    logic [RAM_DEEP:0]   r_cnt;
    logic                r_done;
    logic                w_busy;

    logic                 w_we;
    logic [c_lanes-1:0]   w_be;
    logic [RAM_DEEP-1:0]  w_addr;
    logic [RAM_WIDTH-1:0] w_wdata;
    logic                 w_rd;

    logic [RAM_WIDTH-1:0] r_mem [c_depth];
    logic [RAM_WIDTH-1:0] r_rdata;
    logic                 r_vld;

    assign w_busy = (r_state == S_INIT);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_rst_state;
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.init_req) begin
                        r_state <= S_INIT;
                        r_cnt   <= '0;
                    end
                end
                S_INIT: begin
                    r_cnt <= r_cnt + c_one;
                    if (r_cnt == c_last) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.init_busy = w_busy;
    assign bus.init_done = r_done;

    // While the engine owns the array, user requests are dropped, not deferred.
    always_comb begin
        w_we    = w_busy | bus.wren;
        w_be    = w_busy ? {c_lanes{1'b1}} : bus.byte_en;
        w_addr  = w_busy ? r_cnt[RAM_DEEP-1:0] : bus.address;
        w_wdata = w_busy ? INIT_VALUE : bus.wdata;
        w_rd    = bus.ren & ~w_busy;
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < c_lanes; i++) begin
            if (w_we && w_be[i]) begin
                r_mem[w_addr][i*BYTE_WIDTH +: BYTE_WIDTH] <= w_wdata[i*BYTE_WIDTH +: BYTE_WIDTH];
            end
        end
    end

    // Read samples the array before the same-edge write lands: old data on collision.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_vld   <= 1'b0;
        end else begin
            r_vld <= w_rd;
            if (w_rd) begin
                r_rdata <= r_mem[bus.address];
            end
        end
    end

    generate
        if (RAM_DO_REG != 0) begin : g_out_reg
            logic [RAM_WIDTH-1:0] r_q;
            logic                 r_vld_d;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    r_q     <= '0;
                    r_vld_d <= 1'b0;
                end else begin
                    r_vld_d <= r_vld;
                    if (r_vld) begin
                        r_q <= r_rdata;
                    end
                end
            end

            assign bus.q      = r_q;
            assign bus.rd_vld = r_vld_d;
        end else begin : g_out_direct
            assign bus.q      = r_rdata;
            assign bus.rd_vld = r_vld;
        end
    endgenerate

endmodule
`default_nettype wire
